// File: rtl/pio_write_arbiter.sv
// Round-robin two-requester write arbiter for the 8-bit BNO055 control PIO.
// Define PIO_READBACK_EN to add a readback-verify cycle after each write.
module pio_write_arbiter #(
  parameter int HOLD_CYCLES = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              avm_chipselect,
  output logic [1:0]        avm_address,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              last_grant,
  input  logic              err_clr,
  output logic              verify_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd3
`ifdef PIO_READBACK_EN
    ,READ = 2'd2
`endif
  } state_t;

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  state_t            state_q;
  state_t            state_d;
  state_t            post_st;
  logic              ptr_q;
  logic [CW-1:0]     hold_q;
  logic [DATA_W-1:0] data_q;
  logic              grant;
  logic              idle;
  logic              take;
  logic [DATA_W-1:0] win_data;
  logic              unused_ok;

  assign unused_ok   = ^{avm_readdata, err_clr};
  assign avm_address = 2'b00;
  assign busy        = (state_q != IDLE);
  assign idle        = (state_q == IDLE);
  assign post_st     = (HOLD_CYCLES == 0) ? IDLE : HOLD;

  // Lone requester wins outright; contention falls to the pointer.
  always_comb begin
    grant = ptr_q;
    unique case (1'b1)
      (req0_valid && !req1_valid): grant = 1'b0;
      (req1_valid && !req0_valid): grant = 1'b1;
      default:                     grant = ptr_q;
    endcase
  end

  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign take       = req0_ready || req1_ready;
  assign win_data   = grant ? req1_data : req0_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (take) state_d = WRITE;
`ifdef PIO_READBACK_EN
      WRITE: state_d = READ;
      READ:  state_d = post_st;
`else
      WRITE: state_d = post_st;
`endif
      HOLD:  if (hold_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so they line up
  // with the state cycle they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      hold_q         <= '0;
      data_q         <= '0;
      last_grant     <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        data_q     <= win_data;
        last_grant <= grant;
        ptr_q      <= ~grant;
      end
      if (state_d == HOLD && state_q != HOLD)
        hold_q <= HOLD_LOAD;
      else if (state_q == HOLD && hold_q != '0)
        hold_q <= hold_q - 1'b1;
`ifdef PIO_READBACK_EN
      avm_chipselect <= (state_d == WRITE) ||
                        (state_d == READ);
`else
      avm_chipselect <= (state_d == WRITE);
`endif
      avm_write_n <= (state_d != WRITE);
      if (state_d == WRITE)
        avm_writedata <= 32'(win_data);
    end
  end

`ifdef PIO_READBACK_EN
  logic mismatch;

  assign mismatch = (state_q == READ) &&
    (avm_readdata[DATA_W-1:0] != data_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      verify_err <= 1'b0;
    else if (mismatch)
      verify_err <= 1'b1;
    else if (err_clr)
      verify_err <= 1'b0;
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: default instance plus a
// HOLD_CYCLES=0 instance, readback checks when PIO_READBACK_EN is set.
module tb_pio_write_arbiter;

`ifdef PIO_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int HOLD    = 16;
  localparam int PERIOD  = 2 + HOLD + RB;
  localparam int PERIOD0 = 2 + RB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = '0;
  logic        req1_ready;
  logic        avm_chipselect;
  logic [1:0]  avm_address;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        last_grant;
  logic        err_clr = 1'b0;
  logic        verify_err;

  logic        b_req0_valid = 1'b0;
  logic [7:0]  b_req0_data = '0;
  logic        b_req0_ready;
  logic        b_req1_valid = 1'b0;
  logic [7:0]  b_req1_data = '0;
  logic        unused_b_r1rdy;
  logic        unused_b_cs;
  logic [1:0]  unused_b_addr;
  logic        unused_b_wn;
  logic [31:0] unused_b_wd;
  logic [31:0] b_readdata = '0;
  logic        unused_b_busy;
  logic        unused_b_lg;
  logic        unused_b_ve;

  pio_write_arbiter #(.HOLD_CYCLES(HOLD), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .busy(busy),
    .last_grant(last_grant), .err_clr(err_clr),
    .verify_err(verify_err)
  );

  pio_write_arbiter #(.HOLD_CYCLES(0), .DATA_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data),
    .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data),
    .req1_ready(unused_b_r1rdy),
    .avm_chipselect(unused_b_cs), .avm_address(unused_b_addr),
    .avm_write_n(unused_b_wn), .avm_writedata(unused_b_wd),
    .avm_readdata(b_readdata), .busy(unused_b_busy),
    .last_grant(unused_b_lg), .err_clr(err_clr),
    .verify_err(unused_b_ve)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model; corrupt inverts the readback
  logic [7:0] pio_reg;
  bit         corrupt = 1'b0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) pio_reg <= '0;
    else if (avm_chipselect && !avm_write_n)
      pio_reg <= avm_writedata[7:0];
  assign avm_readdata = {24'h0, corrupt ? ~pio_reg : pio_reg};

  int          acc_cyc[$];
  bit          acc_id[$];
  logic [7:0]  acc_dat[$];
  logic [31:0] wr_dat[$];
  int          wr_cyc[$];
  bit          wr_lg[$];
  int          acc2_cyc[$];
  logic [7:0]  exp_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (req0_valid && req0_ready) begin
        acc_cyc.push_back(cyc); acc_id.push_back(1'b0);
        acc_dat.push_back(req0_data);
      end
      if (req1_valid && req1_ready) begin
        acc_cyc.push_back(cyc); acc_id.push_back(1'b1);
        acc_dat.push_back(req1_data);
      end
      if (avm_chipselect && !avm_write_n) begin
        wr_dat.push_back(avm_writedata);
        wr_cyc.push_back(cyc);
        wr_lg.push_back(last_grant);
      end
      if (b_req0_valid && b_req0_ready)
        acc2_cyc.push_back(cyc);
    end
  end

  int pass = 0;
  int total = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    b_req0_valid = 1'b0; err_clr = 1'b0; corrupt = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    acc_cyc.delete(); acc_id.delete(); acc_dat.delete();
    wr_dat.delete(); wr_cyc.delete(); wr_lg.delete();
    acc2_cyc.delete(); exp_q.delete();
  endtask

  task automatic wait_acc(output int c, output bit id,
                          output logic [7:0] d, output bit ok);
    ok = 1'b0; c = 0; id = 1'b0; d = '0;
    for (int i = 0; i < 200; i++) begin
      if (acc_cyc.size() > 0) begin
        c = acc_cyc.pop_front(); id = acc_id.pop_front();
        d = acc_dat.pop_front(); ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_wr(output logic [31:0] d, output int c,
                         output bit lg, output bit ok);
    ok = 1'b0; d = '0; c = 0; lg = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_dat.size() > 0) begin
        d = wr_dat.pop_front(); c = wr_cyc.pop_front();
        lg = wr_lg.pop_front(); ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int c; bit id; logic [7:0] d; bit ok;
    apply_reset();
    total++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata,
         busy, last_grant, verify_err} !==
        {1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values: cs=%b wn=%b a=%h wd=%h busy=%b lg=%b ve=%b",
               avm_chipselect, avm_write_n, avm_address, avm_writedata,
               busy, last_grant, verify_err);
    else pass++;
    req0_data = 8'h5C; req0_valid = 1'b1;
    wait_acc(c, id, d, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
    total++;
    if ({avm_chipselect, avm_write_n} !== 2'b10)
      $display("FAIL reset_midwrite_pre: cs/wn=%b%b expected 10",
               avm_chipselect, avm_write_n);
    else pass++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({avm_chipselect, avm_write_n, busy, verify_err} !== 4'b0100)
      $display("FAIL reset_abort: cs/wn/busy/ve=%b%b%b%b expected 0100",
               avm_chipselect, avm_write_n, busy, verify_err);
    else pass++;
    @(posedge clk); #1 reset_n = 1'b1;
    acc_cyc.delete(); acc_id.delete(); acc_dat.delete();
    wr_dat.delete(); wr_cyc.delete(); wr_lg.delete();
    req0_data = 8'h01; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(c, id, d, ok);
    total++;
    if (!ok || id !== 1'b0 || d !== 8'h01)
      $display("FAIL reset_first_grant: ok=%b id=%b data=%h expected id 0 data 01",
               ok, id, d);
    else pass++;
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    int t0, t1, wc; bit id, lg, ok, okw;
    logic [7:0] d, e; logic [31:0] w;
    apply_reset();
    req0_data = 8'hA5; req0_valid = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    wait_acc(t0, id, d, ok);
    wait_wr(w, wc, lg, okw);
    e = exp_q.pop_front();
    total++;
    if (!okw || w !== {24'h0, e})
      $display("FAIL single_data: got %h expected %h", w, {24'h0, e});
    else pass++;
    total++;
    if (!ok || wc !== t0 + 1)
      $display("FAIL single_latency: write cycle %0d expected %0d", wc, t0 + 1);
    else pass++;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b1 || avm_chipselect !== 1'b0)
      $display("FAIL single_hold: busy=%b cs=%b expected 1 0",
               busy, avm_chipselect);
    else pass++;
    wait_acc(t1, id, d, ok);
    total++;
    if (!ok || t1 - t0 !== PERIOD)
      $display("FAIL single_period: got %0d expected %0d", t1 - t0, PERIOD);
    else pass++;
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_wr(w, wc, lg, okw);
    e = exp_q.pop_front();
    total++;
    if (!okw || w !== {24'h0, e})
      $display("FAIL single_data2: got %h expected %h", w, {24'h0, e});
    else pass++;
  endtask

  task automatic test_contention();
    int c, prev, wc; bit id, lg, ok, okw;
    logic [7:0] d, e; logic [31:0] w;
    bit exp_id [3] = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_acc(c, id, d, ok);
      if (k == 2) begin
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      end
      total++;
      if (!ok || id !== exp_id[k])
        $display("FAIL contention_id%0d: got %b expected %b", k, id, exp_id[k]);
      else pass++;
      if (k > 0) begin
        total++;
        if (c - prev !== PERIOD)
          $display("FAIL contention_period%0d: got %0d expected %0d",
                   k, c - prev, PERIOD);
        else pass++;
      end
      prev = c;
      wait_wr(w, wc, lg, okw);
      e = exp_q.pop_front();
      total++;
      if (!okw || w !== {24'h0, e} || lg !== exp_id[k])
        $display("FAIL contention_write%0d: data %h lg %b expected %h %b",
                 k, w, lg, {24'h0, e}, exp_id[k]);
      else pass++;
    end
  endtask

  task automatic test_holdoff();
    int t0, t1, wc; bit id, lg, ok, okw, bad;
    logic [7:0] d, e; logic [31:0] w;
    apply_reset();
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    req0_data = 8'h33; req0_valid = 1'b1;
    wait_acc(t0, id, d, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_wr(w, wc, lg, okw);
    e = exp_q.pop_front();
    total++;
    if (!okw || w !== {24'h0, e})
      $display("FAIL holdoff_first: got %h expected %h", w, {24'h0, e});
    else pass++;
    repeat (4) @(posedge clk);
    #1 req1_data = 8'h44; req1_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < PERIOD + 5; i++) begin
      @(negedge clk); #1;
      if (busy && req1_ready) bad = 1'b1;
      if (acc_cyc.size() > 0) break;
    end
    total++;
    if (bad !== 1'b0)
      $display("FAIL holdoff_ready: ready seen while busy (%b) expected 0", bad);
    else pass++;
    wait_acc(t1, id, d, ok);
    total++;
    if (!ok || id !== 1'b1 || t1 - t0 !== PERIOD)
      $display("FAIL holdoff_accept: id %b gap %0d expected 1 %0d",
               id, t1 - t0, PERIOD);
    else pass++;
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_wr(w, wc, lg, okw);
    e = exp_q.pop_front();
    total++;
    if (!okw || w !== {24'h0, e})
      $display("FAIL holdoff_second: got %h expected %h", w, {24'h0, e});
    else pass++;
  endtask

  task automatic test_readback();
    int c; bit id, ok; logic [7:0] d;
    apply_reset();
    corrupt = 1'b1;
    req0_data = 8'hA5; req0_valid = 1'b1;
    wait_acc(c, id, d, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
`ifdef PIO_READBACK_EN
    total++;
    if (verify_err !== 1'b0)
      $display("FAIL rb_pre: verify_err %b expected 0", verify_err);
    else pass++;
    @(posedge clk); #1;
    total++;
    if ({avm_chipselect, avm_write_n} !== 2'b11)
      $display("FAIL rb_read_cycle: cs/wn=%b%b expected 11",
               avm_chipselect, avm_write_n);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (verify_err !== 1'b1)
      $display("FAIL rb_mismatch: verify_err %b expected 1", verify_err);
    else pass++;
    corrupt = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    total++;
    if (verify_err !== 1'b0)
      $display("FAIL rb_clear: verify_err %b expected 0", verify_err);
    else pass++;
    repeat (PERIOD) @(posedge clk);
    #1 corrupt = 1'b1; req0_valid = 1'b1;
    wait_acc(c, id, d, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    total++;
    if (verify_err !== 1'b1)
      $display("FAIL rb_set_wins: verify_err %b expected 1", verify_err);
    else pass++;
`else
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (verify_err !== 1'b0 || !ok)
      $display("FAIL rb_disabled: verify_err %b ok %b expected 0 1",
               verify_err, ok);
    else pass++;
`endif
    corrupt = 1'b0;
  endtask

  task automatic test_hold0();
    apply_reset();
    b_req0_data = 8'h3C; b_req0_valid = 1'b1;
    for (int i = 0; i < 50 && acc2_cyc.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    b_req0_valid = 1'b0;
    total++;
    if (acc2_cyc.size() < 3)
      $display("FAIL hold0_count: %0d accepts expected 3", acc2_cyc.size());
    else pass++;
    if (acc2_cyc.size() >= 3) begin
      total++;
      if (acc2_cyc[1] - acc2_cyc[0] !== PERIOD0)
        $display("FAIL hold0_period1: got %0d expected %0d",
                 acc2_cyc[1] - acc2_cyc[0], PERIOD0);
      else pass++;
      total++;
      if (acc2_cyc[2] - acc2_cyc[1] !== PERIOD0)
        $display("FAIL hold0_period2: got %0d expected %0d",
                 acc2_cyc[2] - acc2_cyc[1], PERIOD0);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_holdoff();
    test_readback();
    test_hold0();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
